// File: rtl/auth_engine.sv
// auth_engine: multi-user credential checker with retry limit and timed lockout.
// Digits arrive on PassSwitches and are entered by a debounced press of PassBtn.
// The ID is matched against ID_TABLE (lowest matching index wins), then the password
// is checked against PW_TABLE for that user. Too many bad passwords lock the block.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   PassSwitches    - digit value to enter
//   PassBtn         - raw (asynchronous) enter button
//   mode            - 00 ID entry, 01 PW entry, 11 logout/clear, 10 no-op
//   timeout         - session/inactivity timeout level
//   LoggedIn        - authenticated session active
//   CheckPassword   - high for the cycle a password compare is made
//   MatchedID       - index of matched user
//   AuthFail        - one-cycle pulse on ID or password mismatch
//   Locked          - lockout active
//   TriesLeft       - remaining password attempts
//   letterLEDs_id   - thermometer of ID digits entered
//   letterLEDs_pw   - thermometer of PW digits entered
module auth_engine #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned ID_LEN    = 6,
    parameter int unsigned PW_LEN    = 6,
    parameter int unsigned NUM_USERS = 4,
    parameter logic [NUM_USERS*ID_LEN*DIGIT_W-1:0] ID_TABLE =
        (NUM_USERS*ID_LEN*DIGIT_W)'(96'h666666_777777_888888_999999),
    parameter logic [NUM_USERS*PW_LEN*DIGIT_W-1:0] PW_TABLE =
        (NUM_USERS*PW_LEN*DIGIT_W)'(96'h444444_333333_222222_111111),
    parameter int unsigned DEB_CYC   = 2,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned LOCK_CYC  = 16,
    localparam int unsigned UID_W    = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    localparam int unsigned TRY_W    = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] PassSwitches,
    input  logic               PassBtn,
    input  logic [1:0]         mode,
    input  logic               timeout,
    output logic               LoggedIn,
    output logic               CheckPassword,
    output logic [UID_W-1:0]   MatchedID,
    output logic               AuthFail,
    output logic               Locked,
    output logic [TRY_W-1:0]   TriesLeft,
    output logic [ID_LEN-1:0]  letterLEDs_id,
    output logic [PW_LEN-1:0]  letterLEDs_pw
);
    localparam int unsigned ID_W   = ID_LEN * DIGIT_W;
    localparam int unsigned PW_W   = PW_LEN * DIGIT_W;
    localparam int unsigned IDC_W  = $clog2(ID_LEN + 1);
    localparam int unsigned PWC_W  = $clog2(PW_LEN + 1);
    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 1);

    typedef enum logic [2:0] {S_ID, S_ID_CHK, S_PW, S_PW_CHK, S_LOGGED, S_LOCK} stateType;

    stateType          state;
    logic [ID_W-1:0]   idBuf;
    logic [PW_W-1:0]   pwBuf;
    logic [IDC_W-1:0]  idCnt;
    logic [PWC_W-1:0]  pwCnt;
    logic [LOCK_W-1:0] lockCnt;

    logic              btnMeta;
    logic              btnSync;
    logic [DEB_W-1:0]  debCnt;
    logic              acceptC;
    logic              clearReqC;
    logic              idTakeC;
    logic              pwTakeC;
    logic              idHitC;
    logic [UID_W-1:0]  idIdxC;
    logic [PW_W-1:0]   pwExpC;
    logic              pwHitC;

    // Button synchroniser and stability counter; counter saturates so one press gives one accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnMeta <= 1'b0;
            btnSync <= 1'b0;
            debCnt  <= '0;
        end else begin
            btnMeta <= PassBtn;
            btnSync <= btnMeta;
            if (!btnSync)
                debCnt <= '0;
            else if (debCnt != DEB_W'(DEB_CYC))
                debCnt <= debCnt + DEB_W'(1);
        end
    end

    assign acceptC   = btnSync && (debCnt == DEB_W'(DEB_CYC - 1));
    assign clearReqC = (mode == 2'b11) || timeout;
    assign idTakeC   = acceptC && (state == S_ID) && (mode == 2'b00);
    assign pwTakeC   = acceptC && (state == S_PW) && (mode == 2'b01);

    // Parallel table compare; scanning downward leaves the lowest matching index
    always_comb begin
        idHitC = 1'b0;
        idIdxC = '0;
        pwExpC = '0;
        for (int u = int'(NUM_USERS) - 1; u >= 0; u--) begin
            if (idBuf == ID_TABLE[u*ID_W +: ID_W]) begin
                idHitC = 1'b1;
                idIdxC = UID_W'(u);
            end
            if (MatchedID == UID_W'(u))
                pwExpC = PW_TABLE[u*PW_W +: PW_W];
        end
        pwHitC = (pwBuf == pwExpC);
    end

    // Main control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_ID;
            idBuf         <= '0;
            pwBuf         <= '0;
            idCnt         <= '0;
            pwCnt         <= '0;
            lockCnt       <= '0;
            LoggedIn      <= 1'b0;
            CheckPassword <= 1'b0;
            MatchedID     <= '0;
            AuthFail      <= 1'b0;
            Locked        <= 1'b0;
            TriesLeft     <= TRY_W'(MAX_TRIES);
            letterLEDs_id <= '0;
            letterLEDs_pw <= '0;
        end else begin
            CheckPassword <= 1'b0;
            AuthFail      <= 1'b0;
            if (state == S_LOCK) begin
                // Lockout ignores mode and timeout until it expires
                if (lockCnt == LOCK_W'(LOCK_CYC - 1)) begin
                    state     <= S_ID;
                    Locked    <= 1'b0;
                    TriesLeft <= TRY_W'(MAX_TRIES);
                    MatchedID <= '0;
                    lockCnt   <= '0;
                end else begin
                    lockCnt <= lockCnt + LOCK_W'(1);
                end
            end else if (clearReqC) begin
                // Logout/timeout wins over a same-cycle digit or check result
                state         <= S_ID;
                LoggedIn      <= 1'b0;
                MatchedID     <= '0;
                idBuf         <= '0;
                pwBuf         <= '0;
                idCnt         <= '0;
                pwCnt         <= '0;
                letterLEDs_id <= '0;
                letterLEDs_pw <= '0;
            end else begin
                case (state)
                    S_ID: if (idTakeC) begin
                        for (int i = 0; i < int'(ID_LEN); i++) begin
                            if (idCnt == IDC_W'(i)) begin
                                idBuf[i*DIGIT_W +: DIGIT_W] <= PassSwitches;
                                letterLEDs_id[i]            <= 1'b1;
                            end
                        end
                        idCnt <= idCnt + IDC_W'(1);
                        if (idCnt == IDC_W'(ID_LEN - 1))
                            state <= S_ID_CHK;
                    end
                    S_ID_CHK: if (idHitC) begin
                        MatchedID <= idIdxC;
                        state     <= S_PW;
                    end else begin
                        AuthFail      <= 1'b1;
                        idBuf         <= '0;
                        idCnt         <= '0;
                        letterLEDs_id <= '0;
                        state         <= S_ID;
                    end
                    S_PW: if (pwTakeC) begin
                        for (int i = 0; i < int'(PW_LEN); i++) begin
                            if (pwCnt == PWC_W'(i)) begin
                                pwBuf[i*DIGIT_W +: DIGIT_W] <= PassSwitches;
                                letterLEDs_pw[i]            <= 1'b1;
                            end
                        end
                        pwCnt <= pwCnt + PWC_W'(1);
                        if (pwCnt == PWC_W'(PW_LEN - 1)) begin
                            state         <= S_PW_CHK;
                            CheckPassword <= 1'b1;
                        end
                    end
                    S_PW_CHK: if (pwHitC) begin
                        state         <= S_LOGGED;
                        LoggedIn      <= 1'b1;
                        TriesLeft     <= TRY_W'(MAX_TRIES);
                        letterLEDs_id <= '1;
                        letterLEDs_pw <= '1;
                    end else begin
                        AuthFail      <= 1'b1;
                        pwBuf         <= '0;
                        pwCnt         <= '0;
                        letterLEDs_pw <= '0;
                        if (TriesLeft == TRY_W'(1)) begin
                            state         <= S_LOCK;
                            Locked        <= 1'b1;
                            TriesLeft     <= '0;
                            lockCnt       <= '0;
                            idBuf         <= '0;
                            idCnt         <= '0;
                            letterLEDs_id <= '0;
                        end else begin
                            TriesLeft <= TriesLeft - TRY_W'(1);
                            state     <= S_PW;
                        end
                    end
                    S_LOGGED: begin
                    end
                    default: state <= S_ID;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_auth_engine.sv
// Self-checking bench for auth_engine: table-driven login vectors, event scoreboard
// for CheckPassword/AuthFail pulses, and hand sequences for debounce, timeout,
// lockout and asynchronous reset.
module tb_auth_engine;
    logic       clk;
    logic       rst;
    logic [3:0] PassSwitches;
    logic       PassBtn;
    logic [1:0] mode;
    logic       timeout;
    logic       LoggedIn;
    logic       CheckPassword;
    logic [1:0] MatchedID;
    logic       AuthFail;
    logic       Locked;
    logic [1:0] TriesLeft;
    logic [5:0] letterLEDs_id;
    logic [5:0] letterLEDs_pw;

    int errors = 0;
    int checks = 0;
    int lockedCycles = 0;

    typedef struct packed {
        logic       isFail;
        logic [1:0] uid;
    } evT;
    evT evQ[$];

    typedef struct {
        logic [3:0] idDig;
        logic [3:0] pwDig;
        logic       idOk;
        logic       pwOk;
        logic [1:0] uid;
        logic [1:0] tries;
    } vecT;
    vecT vecs[6];

    auth_engine dut (
        .clk(clk), .rst(rst), .PassSwitches(PassSwitches), .PassBtn(PassBtn),
        .mode(mode), .timeout(timeout), .LoggedIn(LoggedIn), .CheckPassword(CheckPassword),
        .MatchedID(MatchedID), .AuthFail(AuthFail), .Locked(Locked), .TriesLeft(TriesLeft),
        .letterLEDs_id(letterLEDs_id), .letterLEDs_pw(letterLEDs_pw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushEv(input logic isFail, input logic [1:0] uid);
        evT e;
        e.isFail = isFail;
        e.uid    = uid;
        evQ.push_back(e);
    endtask

    task automatic popEv(input logic isFail);
        evT e;
        if (evQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got isFail=%0d with no pending event", isFail);
        end else begin
            e = evQ.pop_front();
            chk("event_kind", 32'(isFail), 32'(e.isFail));
            chk("event_uid", 32'(MatchedID), 32'(e.uid));
        end
    endtask

    // Scoreboard side: pulses observed on the falling edge are matched against queued events
    always @(negedge clk) begin
        if (!rst) begin
            if (Locked) lockedCycles++;
            if (CheckPassword) popEv(1'b0);
            if (AuthFail) popEv(1'b1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        PassSwitches = d;
        PassBtn = 1'b1;
        cyc(hold);
        PassBtn = 1'b0;
        cyc(5);
    endtask

    task automatic clearSession();
        mode = 2'b11;
        cyc(2);
        mode = 2'b10;
        cyc(1);
    endtask

    // User 0 ID, then three wrong passwords ending in lockout
    task automatic lockAttempts();
        mode = 2'b00;
        for (int i = 0; i < 6; i++) press(4'd9, 3);
        chk("lock_id_matched", 32'(MatchedID), 32'd0);
        mode = 2'b01;
        for (int a = 0; a < 3; a++) begin
            pushEv(1'b0, 2'd0);
            pushEv(1'b1, 2'd0);
            if (a == 2) lockedCycles = 0;
            for (int i = 0; i < 6; i++) press(4'd2, 3);
            if (a < 2) begin
                chk($sformatf("lock_tries_%0d", a), 32'(TriesLeft), 32'(2 - a));
                chk($sformatf("lock_notlocked_%0d", a), 32'(Locked), 32'd0);
                chk($sformatf("lock_pwled_%0d", a), 32'(letterLEDs_pw), 32'd0);
            end else begin
                chk("lock_locked", 32'(Locked), 32'd1);
                chk("lock_tries_zero", 32'(TriesLeft), 32'd0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd9, 4'd1, 1'b1, 1'b1, 2'd0, 2'd3};
        vecs[1] = '{4'd7, 4'd3, 1'b1, 1'b1, 2'd2, 2'd3};
        vecs[2] = '{4'd5, 4'd0, 1'b0, 1'b0, 2'd0, 2'd3};
        vecs[3] = '{4'd8, 4'd3, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[4] = '{4'd6, 4'd4, 1'b1, 1'b1, 2'd3, 2'd3};
        vecs[5] = '{4'd8, 4'd2, 1'b1, 1'b1, 2'd1, 2'd3};

        rst = 1'b0; PassSwitches = '0; PassBtn = 1'b0; mode = 2'b10; timeout = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_loggedin", 32'(LoggedIn), 32'd0);
        chk("rst_locked", 32'(Locked), 32'd0);
        chk("rst_tries", 32'(TriesLeft), 32'd3);
        chk("rst_matched", 32'(MatchedID), 32'd0);
        chk("rst_leds", 32'({letterLEDs_id, letterLEDs_pw}), 32'd0);
        chk("rst_pulses", 32'({CheckPassword, AuthFail}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc(1);

        // Table-driven login vectors
        for (int r = 0; r < 6; r++) begin
            mode = 2'b00;
            if (!vecs[r].idOk) pushEv(1'b1, 2'd0);
            for (int i = 0; i < 6; i++) begin
                press(vecs[r].idDig, 3);
                if (i < 5)
                    chk($sformatf("row%0d_idled%0d", r, i), 32'(letterLEDs_id), (32'd1 << (i + 1)) - 32'd1);
            end
            if (!vecs[r].idOk) begin
                chk($sformatf("row%0d_idfail_led", r), 32'(letterLEDs_id), 32'd0);
                chk($sformatf("row%0d_idfail_tries", r), 32'(TriesLeft), 32'(vecs[r].tries));
                chk($sformatf("row%0d_idfail_login", r), 32'(LoggedIn), 32'd0);
            end else begin
                chk($sformatf("row%0d_idled_full", r), 32'(letterLEDs_id), 32'h3f);
                chk($sformatf("row%0d_matched", r), 32'(MatchedID), 32'(vecs[r].uid));
                mode = 2'b01;
                pushEv(1'b0, vecs[r].uid);
                if (!vecs[r].pwOk) pushEv(1'b1, vecs[r].uid);
                for (int i = 0; i < 6; i++) begin
                    press(vecs[r].pwDig, 3);
                    if (i < 5)
                        chk($sformatf("row%0d_pwled%0d", r, i), 32'(letterLEDs_pw), (32'd1 << (i + 1)) - 32'd1);
                end
                chk($sformatf("row%0d_login", r), 32'(LoggedIn), 32'(vecs[r].pwOk));
                chk($sformatf("row%0d_tries", r), 32'(TriesLeft), 32'(vecs[r].tries));
                chk($sformatf("row%0d_pwled", r), 32'(letterLEDs_pw), vecs[r].pwOk ? 32'h3f : 32'd0);
                chk($sformatf("row%0d_idled_after", r), 32'(letterLEDs_id), 32'h3f);
            end
            clearSession();
            chk($sformatf("row%0d_clr_login", r), 32'(LoggedIn), 32'd0);
            chk($sformatf("row%0d_clr_matched", r), 32'(MatchedID), 32'd0);
            chk($sformatf("row%0d_clr_leds", r), 32'({letterLEDs_id, letterLEDs_pw}), 32'd0);
            chk($sformatf("row%0d_clr_tries", r), 32'(TriesLeft), 32'(vecs[r].tries));
        end

        // Debounce and mode gating
        mode = 2'b00;
        press(4'd9, 1);
        chk("deb_short", 32'(letterLEDs_id), 32'd0);
        press(4'd9, 50);
        chk("deb_long", 32'(letterLEDs_id), 32'd1);
        mode = 2'b10;
        press(4'd9, 3);
        chk("deb_mode10", 32'(letterLEDs_id), 32'd1);
        clearSession();

        // Timeout ends a session
        mode = 2'b00;
        for (int i = 0; i < 6; i++) press(4'd9, 3);
        mode = 2'b01;
        pushEv(1'b0, 2'd0);
        for (int i = 0; i < 6; i++) press(4'd1, 3);
        chk("to_login", 32'(LoggedIn), 32'd1);
        timeout = 1'b1;
        cyc(1);
        timeout = 1'b0;
        chk("to_logout", 32'(LoggedIn), 32'd0);
        chk("to_leds", 32'({letterLEDs_id, letterLEDs_pw}), 32'd0);

        // Timeout on the same cycle as the third ID accept discards the digit
        mode = 2'b00;
        press(4'd9, 3);
        press(4'd9, 3);
        chk("to_two_digits", 32'(letterLEDs_id), 32'd3);
        PassSwitches = 4'd9;
        PassBtn = 1'b1;
        cyc(2);
        PassBtn = 1'b0;
        cyc(1);
        timeout = 1'b1;
        cyc(1);
        timeout = 1'b0;
        chk("to_same_cycle", 32'(letterLEDs_id), 32'd0);
        cyc(4);
        press(4'd9, 3);
        chk("to_restart_idx", 32'(letterLEDs_id), 32'd1);
        clearSession();

        // Lockout: duration, ignored presses, recovery
        lockAttempts();
        mode = 2'b00;
        press(4'd9, 3);
        chk("lock_press_ignored", 32'(letterLEDs_id), 32'd0);
        for (int i = 0; i < 40 && Locked; i++) cyc(1);
        chk("lock_released", 32'(Locked), 32'd0);
        chk("lock_cycles", 32'(lockedCycles), 32'd16);
        chk("lock_tries_reload", 32'(TriesLeft), 32'd3);
        chk("lock_matched_clr", 32'(MatchedID), 32'd0);
        press(4'd9, 3);
        chk("lock_back_in_id", 32'(letterLEDs_id), 32'd1);
        clearSession();

        // Asynchronous reset during lockout
        lockAttempts();
        cyc(3);
        rst = 1'b1;
        #2;
        chk("arst_locked", 32'(Locked), 32'd0);
        chk("arst_tries", 32'(TriesLeft), 32'd3);
        chk("arst_leds", 32'({letterLEDs_id, letterLEDs_pw}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);

        chk("events_drained", 32'(evQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/auth_engine.md
Name: auth_engine

Overview:
Parametrised successor to the single-user Authentication block. It accepts ID and password digits from switches plus a push-button, and matches the ID against a NUM_USERS credential table. It verifies the password of the matched user, enforces a retry limit with timed lockout, and drives progress LEDs. It sits between the board switch/button inputs and the Morse decoder session logic, which is enabled by LoggedIn.

Parameters:
DIGIT_W, 4, bits per entered digit (PassSwitches width)
ID_LEN, 6, digits per ID
PW_LEN, 6, digits per password
NUM_USERS, 4, credential table entries; UID_W = max(1, clog2(NUM_USERS))
ID_TABLE, user u: all ID digits = 9-u, packed NUM_USERS*ID_LEN*DIGIT_W; user u at [u*ID_LEN*DIGIT_W +: ID_LEN*DIGIT_W]; digit i at [i*DIGIT_W +: DIGIT_W] within the entry
PW_TABLE, user u: all PW digits = u+1, packed the same way with PW_LEN
DEB_CYC, 2, cycles synchronised button must stay high to register a press
MAX_TRIES, 3, failed password attempts before lockout
LOCK_CYC, 16, lockout duration in cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
PassSwitches  in  DIGIT_W  digit value
PassBtn  in  1  raw enter button (asynchronous)
mode  in  2  00 ID entry, 01 PW entry, 11 logout/clear, 10 no-op
timeout  in  1  session/inactivity timeout, level
LoggedIn  out  1  authenticated session active
CheckPassword  out  1  one-cycle pulse when a password compare is performed
MatchedID  out  UID_W  index of matched user
AuthFail  out  1  one-cycle pulse on ID or password mismatch
Locked  out  1  lockout active
TriesLeft  out  clog2(MAX_TRIES+1)  remaining password attempts
letterLEDs_id  out  ID_LEN  thermometer of ID digits entered
letterLEDs_pw  out  PW_LEN  thermometer of PW digits entered

Behaviour:
- Reset (async, immediate): state S_ID; all outputs 0 except TriesLeft=MAX_TRIES; digit buffers, counters and debounce logic cleared.
- Button path: 2-FF synchroniser, then a stability counter. An accept pulse (1 cycle) fires on the cycle the synchronised level has been high DEB_CYC consecutive cycles. Exactly one accept per press; the button must go low before the next accept.
- Digit capture: on accept, PassSwitches is stored at digit index = entry count, count increments, and LED bit[count] is set. Accepted only if (S_ID and mode==00) or (S_PW and mode==01); otherwise discarded.
- States: S_ID, S_ID_CHK, S_PW, S_PW_CHK, S_LOGGED, S_LOCK.
- S_ID -> S_ID_CHK on the cycle after the ID_LEN-th digit is accepted.
- S_ID_CHK (1 cycle) compares the buffer with all table entries in parallel; the lowest matching index wins.
  - Match: MatchedID <= index, -> S_PW.
  - No match: AuthFail pulse, ID buffer/LEDs cleared, -> S_ID. Tries are not decremented.
- S_PW -> S_PW_CHK after the PW_LEN-th digit is accepted.
- S_PW_CHK (1 cycle): CheckPassword=1 and the compare is against PW_TABLE[MatchedID].
  - Match: -> S_LOGGED; LoggedIn rises the next cycle; TriesLeft reloads to MAX_TRIES.
  - Mismatch: AuthFail pulse, TriesLeft decrements, PW buffer/LEDs cleared, -> S_PW. If TriesLeft was 1: -> S_LOCK instead.
- S_LOCK: Locked=1 and both buffers are cleared. After LOCK_CYC cycles: -> S_ID, Locked=0, TriesLeft=MAX_TRIES, MatchedID=0. mode and timeout are ignored while locked.
- S_LOGGED: LoggedIn=1, letterLEDs_id and letterLEDs_pw all 1, and digit accepts are ignored. mode==11 or timeout -> S_ID with everything cleared (LoggedIn falls next cycle).
- mode==11 or timeout in S_ID/S_PW/check states: clear buffers and LEDs, MatchedID=0, -> S_ID. TriesLeft is kept.
- Simultaneous events: timeout/clear beats a same-cycle accept (the digit is discarded), and beats a check-state result.
- Reset mid-lockout or mid-session returns to the reset state immediately.

Test Plan:
- Reset, mode 00, six presses of 9 -> letterLEDs_id 000001..111111, MatchedID=0, S_PW. Mode 01, six presses of 1 -> CheckPassword one pulse, then LoggedIn=1.
- ID 777777 then PW 333333 -> MatchedID=2, LoggedIn=1. ID 555555 -> AuthFail pulse, letterLEDs_id=0, TriesLeft=3.
- User 0, wrong PW 222222 three times -> TriesLeft 2,1, then Locked=1 for 16 cycles. Presses during lockout are ignored. Afterwards TriesLeft=3 and state is S_ID.
- Button held 1 cycle (DEB_CYC=2) -> no digit; held 50 cycles -> exactly one digit. Press with mode 10 -> no digit.
- Logged in, then timeout=1 -> LoggedIn=0 next cycle, LEDs 0. Timeout asserted the same cycle as the 3rd ID accept -> letterLEDs_id=0.
- rst asserted mid-lockout -> Locked=0 and TriesLeft=3 without waiting for a clock edge.
